// File: rtl/ff_width_packer.sv
// ff_width_packer
// Collects DW-bit words from a first-word-fall-through FIFO head and emits
// them as RATIO-word beats over a valid/ready handshake. A flush pulse closes
// a partially filled beat so tail data is delivered instead of stranded.
//
// Build option: FF_PACK_ZERO_PAD_EN
//   defined   - unused upper slots of a flush-closed beat are driven to zero
//   undefined - those slots carry whatever the accumulator last held there;
//               receivers must rely on o_cnt
module ff_width_packer #(
  parameter int DW    = 8,
  parameter int RATIO = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ffrvld,
  input  logic [DW-1:0]           ffrdata,
  input  logic                    ffrempty,
  output logic                    ffrreq,
  input  logic                    flush,
  output logic                    o_vld,
  input  logic                    o_rdy,
  output logic [DW*RATIO-1:0]     o_data,
  output logic [$clog2(RATIO):0]  o_cnt,
  output logic                    o_last
);

  localparam int CW = $clog2(RATIO);
  localparam int OW = CW + 1;
  localparam int BW = DW * RATIO;
  localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);
  localparam logic [OW-1:0] FULL_CNT  = OW'(RATIO);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   wcnt;
  logic [CW-1:0]   wcnt_next;
  logic            flush_pend;
  logic            pend_next;
  logic            flush_eff;
  logic [BW-1:0]   acc;
  logic [BW-1:0]   acc_next;
  logic [BW-1:0]   data_next;
  logic [OW-1:0]   cnt_next;
  logic            last_next;

  // Emptiness is implied by ffrvld on a FWFT port, so this input is not needed.
  logic unused_empty;
  assign unused_empty = ffrempty;

  // The beat is presented exactly while the FSM is holding it.
  assign o_vld = (state == HOLD);

  // Builds the beat image for a flush-closed partial beat of n words.
  function automatic logic [BW-1:0] close_partial(input logic [BW-1:0] a,
                                                  input logic [CW-1:0] n);
    logic [BW-1:0] b;
    b = a;
`ifdef FF_PACK_ZERO_PAD_EN
    for (int k = 0; k < RATIO; k++) begin
      if (k >= int'(n)) begin
        b[k*DW +: DW] = '0;
      end
    end
`else
    if (n == '0) begin
      b = a;
    end
`endif
    return b;
  endfunction

  // Next-state, pop request and next beat contents; flush beats pop in FILL.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    pend_next  = flush_pend;
    acc_next   = acc;
    data_next  = o_data;
    cnt_next   = o_cnt;
    last_next  = o_last;
    ffrreq     = 1'b0;
    flush_eff  = flush | flush_pend;

    case (state)
      FILL: begin
        if (flush_eff) begin
          pend_next = 1'b0;
          if (wcnt != '0) begin
            state_next = HOLD;
            data_next  = close_partial(acc, wcnt);
            cnt_next   = {1'b0, wcnt};
            last_next  = 1'b1;
            wcnt_next  = '0;
          end
        end else begin
          ffrreq = ffrvld;
          if (ffrvld) begin
            acc_next[wcnt*DW +: DW] = ffrdata;
            if (wcnt == LAST_SLOT) begin
              state_next = HOLD;
              data_next  = acc_next;
              cnt_next   = FULL_CNT;
              last_next  = 1'b0;
              wcnt_next  = '0;
            end else begin
              wcnt_next = wcnt + 1'b1;
            end
          end
        end
      end

      HOLD: begin
        ffrreq = ffrvld & o_rdy;
        if (flush) begin
          pend_next = 1'b1;
        end
        if (o_rdy) begin
          state_next = FILL;
          if (ffrvld) begin
            acc_next[DW-1:0] = ffrdata;
            wcnt_next        = CW'(1);
          end else begin
            wcnt_next = '0;
          end
        end
      end

      default: begin
        state_next = FILL;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Accumulator, word count, pending flush and the presented beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt       <= '0;
      flush_pend <= 1'b0;
      acc        <= '0;
      o_data     <= '0;
      o_cnt      <= '0;
      o_last     <= 1'b0;
    end else begin
      wcnt       <= wcnt_next;
      flush_pend <= pend_next;
      acc        <= acc_next;
      o_data     <= data_next;
      o_cnt      <= cnt_next;
      o_last     <= last_next;
    end
  end

endmodule

// File: tb/tb_ff_width_packer.sv
// Bench for ff_width_packer (DW=8, RATIO=4): a queue-based FIFO source, a
// word-list model of the packer checked every cycle, and hand-written beats.
module tb_ff_width_packer;

  localparam int DW    = 8;
  localparam int RATIO = 4;
  localparam int BW    = DW * RATIO;
  localparam int OW    = $clog2(RATIO) + 1;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          ffrvld   = 1'b0;
  logic [DW-1:0] ffrdata  = '0;
  logic          ffrempty = 1'b1;
  logic          ffrreq;
  logic          flush    = 1'b0;
  logic          o_vld;
  logic          o_rdy    = 1'b0;
  logic [BW-1:0] o_data;
  logic [OW-1:0] o_cnt;
  logic          o_last;

  typedef struct {
    logic [BW-1:0] data;
    logic [BW-1:0] mask;
    int            cnt;
    bit            last;
  } beat_t;

  logic [DW-1:0] fifo_q[$];
  beat_t         exp_beats[$];

  logic [DW-1:0] m_acc[$];
  logic [DW-1:0] m_beat[$];
  bit            m_hold = 0;
  bit            m_pend = 0;
  bit            m_last = 0;
  int            m_cnt  = 0;

  int total = 0;
  int bad   = 0;
  bit end_req  = 0;
  bit end_done = 0;

  ff_width_packer #(.DW(DW), .RATIO(RATIO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ffrvld   (ffrvld),
    .ffrdata  (ffrdata),
    .ffrempty (ffrempty),
    .ffrreq   (ffrreq),
    .flush    (flush),
    .o_vld    (o_vld),
    .o_rdy    (o_rdy),
    .o_data   (o_data),
    .o_cnt    (o_cnt),
    .o_last   (o_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_head();
    ffrvld   = (fifo_q.size() > 0);
    ffrdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'hEE;
    ffrempty = (fifo_q.size() == 0);
  endtask

  // Compare process: checks DUT against the model just before each rising edge.
  initial begin : compare
    bit exp_req;
    bit fifo_pop;
    beat_t eb;
    forever begin
      @(negedge clk);
      #2 drive_head();
      #2;
      fifo_pop = 0;
      if (!reset_n) begin
        checkOutput("rst_vld",  o_vld,  0);
        checkOutput("rst_data", o_data, 0);
        checkOutput("rst_cnt",  o_cnt,  0);
        checkOutput("rst_last", o_last, 0);
        checkOutput("rst_req",  ffrreq, 0);
        m_hold = 0;
        m_pend = 0;
        m_acc.delete();
      end else begin
        exp_req = m_hold ? (ffrvld && o_rdy) : (!(flush || m_pend) && ffrvld);
        checkOutput("ffrreq", ffrreq, exp_req);
        checkOutput("o_vld",  o_vld,  m_hold);
        fifo_pop = ffrreq && ffrvld;
        if (m_hold) begin
          checkOutput("o_cnt",  o_cnt,  m_cnt);
          checkOutput("o_last", o_last, m_last);
          for (int k = 0; k < m_cnt; k++) begin
            checkOutput($sformatf("slot%0d", k), o_data[k*DW +: DW], m_beat[k]);
          end
`ifdef FF_PACK_ZERO_PAD_EN
          for (int k = m_cnt; k < RATIO; k++) begin
            checkOutput($sformatf("pad%0d", k), o_data[k*DW +: DW], 0);
          end
`endif
          if (o_rdy) begin
            checkOutput("lit_pending", exp_beats.size() > 0, 1);
            if (exp_beats.size() > 0) begin
              eb = exp_beats.pop_front();
              checkOutput("lit_data", o_data & eb.mask, eb.data & eb.mask);
              checkOutput("lit_cnt",  o_cnt,  eb.cnt);
              checkOutput("lit_last", o_last, eb.last);
            end
          end
        end
        // Advance the model across the coming edge.
        if (!m_hold) begin
          if (flush || m_pend) begin
            m_pend = 0;
            if (m_acc.size() > 0) begin
              m_beat = m_acc;
              m_cnt  = m_acc.size();
              m_last = 1;
              m_hold = 1;
              m_acc.delete();
            end
          end else if (ffrvld) begin
            m_acc.push_back(ffrdata);
            if (m_acc.size() == RATIO) begin
              m_beat = m_acc;
              m_cnt  = RATIO;
              m_last = 0;
              m_hold = 1;
              m_acc.delete();
            end
          end
        end else begin
          if (flush) m_pend = 1;
          if (o_rdy) begin
            m_hold = 0;
            if (ffrvld) m_acc.push_back(ffrdata);
          end
        end
      end
      if (end_req && !end_done) begin
        checkOutput("lit_left",  exp_beats.size(), 0);
        checkOutput("fifo_left", fifo_q.size(), 0);
        end_done = 1;
      end
      @(posedge clk);
      #1;
      if (fifo_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_head();
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic expect_beat(input logic [BW-1:0] d, input logic [BW-1:0] m,
                             input int c, input bit l);
    beat_t b;
    b.data = d;
    b.mask = m;
    b.cnt  = c;
    b.last = l;
    exp_beats.push_back(b);
  endtask

`ifdef FF_PACK_ZERO_PAD_EN
  localparam logic [BW-1:0] MASK2 = 32'hFFFF_FFFF;
  localparam logic [BW-1:0] MASK1 = 32'hFFFF_FFFF;
`else
  localparam logic [BW-1:0] MASK2 = 32'h0000_FFFF;
  localparam logic [BW-1:0] MASK1 = 32'h0000_00FF;
`endif

  task automatic applyStimulus();
    // Reset at start.
    cycles(3);
    #1 reset_n = 1'b1;
    cycles(1);

    // Full beat, continuous.
    o_rdy = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    expect_beat(32'h4433_2211, 32'hFFFF_FFFF, 4, 0);
    cycles(8);

    // Back-pressure across two beats.
    o_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    expect_beat(32'h0403_0201, 32'hFFFF_FFFF, 4, 0);
    expect_beat(32'h0807_0605, 32'hFFFF_FFFF, 4, 0);
    cycles(9);
    o_rdy = 1'b1;
    cycles(10);

    // Partial flush with a third word waiting at the head.
    push(8'hAA); push(8'hBB); push(8'hCC);
    expect_beat(32'h0000_BBAA, MASK2, 2, 1);
    expect_beat(32'h0000_00CC, MASK1, 1, 1);
    cycles(2);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(3);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(4);

    // Flush while empty emits nothing; next four words form a normal beat.
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(2);
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    expect_beat(32'h6463_6261, 32'hFFFF_FFFF, 4, 0);
    cycles(8);

    // Flush during HOLD is deferred to the next beat.
    o_rdy = 1'b0;
    push(8'h71); push(8'h72); push(8'h73); push(8'h74); push(8'h5A);
    expect_beat(32'h7473_7271, 32'hFFFF_FFFF, 4, 0);
    expect_beat(32'h0000_005A, MASK1, 1, 1);
    cycles(6);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(2);
    o_rdy = 1'b1;
    cycles(6);

    // Reset mid-beat after three pops.
    push(8'h81); push(8'h82); push(8'h83);
    cycles(4);
    #1 reset_n = 1'b0;
    fifo_q.delete();
    cycles(2);
    #1 reset_n = 1'b1;
    cycles(1);
    push(8'h91); push(8'h92); push(8'h93); push(8'h94);
    expect_beat(32'h9493_9291, 32'hFFFF_FFFF, 4, 0);
    cycles(8);
  endtask

  initial begin : stimulus
    $display("[TB] start");
    applyStimulus();
    end_req = 1;
    cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
